// File: rtl/bcd_counter_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_display
// Description : N-digit BCD up/down counter with a prescaler, synchronous load
//               (digits above 9 saturate to 9) and a registered active-low
//               7-segment decode (bit 6 = a ... bit 0 = g) for every digit.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zero
//               digits (digit 0 is never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  tick,
    output logic                  wrap
);

    localparam int              C_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(PRESCALE - 1);
    localparam logic [6:0]      C_SEG_BLANK = 7'b1111111;

    // Active-low abcdefg pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = C_SEG_BLANK;
        endcase
        return s;
    endfunction

    // Display contents for a count of zero, matching the decode of bcd = 0.
    function automatic logic [7*DIGITS-1:0] hex_reset_value();
        logic [7*DIGITS-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            v[7*i+:7] = (i == 0) ? seg7(4'd0) : C_SEG_BLANK;
`else
            v[7*i+:7] = seg7(4'd0);
`endif
        end
        return v;
    endfunction

    localparam logic [7*DIGITS-1:0] C_HEX_RST = hex_reset_value();

    logic [C_PS_W-1:0]   prescaler_q, prescaler_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;

    logic [4*DIGITS-1:0] w_step_val;
    logic                w_step_wrap;
    logic [4*DIGITS-1:0] w_load_sat;

    // Ripple one decimal step through the digits; carry/borrow out of the top is a wrap.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        carry      = 1'b1;
        w_step_val = cnt_q;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i+:4];
            if (carry) begin
                if (up_dn) begin
                    if (dig >= 4'd9) begin
                        w_step_val[4*i+:4] = 4'd0;
                    end else begin
                        w_step_val[4*i+:4] = dig + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        w_step_val[4*i+:4] = 4'd9;
                    end else begin
                        w_step_val[4*i+:4] = dig - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        w_step_wrap = carry;
    end

    // Saturate each load digit to 9 so the count register only ever holds BCD.
    always_comb begin
        w_load_sat = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i+:4] > 4'd9) begin
                w_load_sat[4*i+:4] = 4'd9;
            end
        end
    end

    // Next-state: load wins over a step; the step happens on prescaler expiry.
    always_comb begin
        prescaler_d = prescaler_q;
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;
        if (load) begin
            cnt_d       = w_load_sat;
            prescaler_d = '0;
        end else if (en) begin
            if (prescaler_q == C_PS_LAST) begin
                prescaler_d = '0;
                tick_d      = 1'b1;
                cnt_d       = w_step_val;
                wrap_d      = w_step_wrap;
            end else begin
                prescaler_d = prescaler_q + 1'b1;
            end
        end
    end

    // Decode the current count; the registered result lags bcd_out by one cycle.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic all_zero;
        all_zero = 1'b1;
`endif
        hex_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hex_d[7*i+:7] = seg7(cnt_q[4*i+:4]);
`ifdef LEADING_ZERO_BLANK_EN
            all_zero = all_zero && (cnt_q[4*i+:4] == 4'd0);
            if ((i > 0) && all_zero) begin
                hex_d[7*i+:7] = C_SEG_BLANK;
            end
`endif
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            prescaler_q <= '0;
            cnt_q       <= '0;
            hex_q       <= C_HEX_RST;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            cnt_q       <= cnt_d;
            hex_q       <= hex_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bcd_out = cnt_q;
    assign hex_out = hex_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule
`default_nettype wire
